// File: rtl/gate_demux_1to4.sv
// gate_demux_1to4: registered 1-to-4 stream distributor with single-entry output slots and auto gate pointer
module gate_demux_1to4 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             auto_mode,
  input  logic [1:0]       sel,
  input  logic             ptr_clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       gate_ptr,
  output logic             set_done
);
  logic [1:0] dest;
  logic [3:0] free, load;
  logic       acc;
  assign dest     = auto_mode ? gate_ptr : sel;
  assign free     = ~out_valid | out_ready;
  assign in_ready = en && free[dest];
  assign acc      = in_valid && in_ready;
  assign load     = acc ? 4'b0001 << dest : 4'b0000;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data0 <= '0;
      out_data1 <= '0;
      out_data2 <= '0;
      out_data3 <= '0;
      gate_ptr  <= '0;
      set_done  <= 1'b0;
    end else begin
      // a load into a slot being drained keeps it valid with the new word
      out_valid <= load | (out_valid & ~out_ready);
      if (load[0]) out_data0 <= in_data;
      if (load[1]) out_data1 <= in_data;
      if (load[2]) out_data2 <= in_data;
      if (load[3]) out_data3 <= in_data;
      gate_ptr  <= ptr_clr ? 2'd0 : (acc && auto_mode) ? gate_ptr + 2'd1 : gate_ptr;
      set_done  <= acc && auto_mode && gate_ptr == 2'd3;
    end
  end
endmodule

// File: tb/tb_gate_demux_1to4.sv
// tb_gate_demux_1to4: directed scenarios plus randomized run against a per-slot behavioural model
module tb_gate_demux_1to4;
  localparam int W = 64;
  logic clk = 0, rst = 0, en = 0, auto_mode = 0, ptr_clr = 0, in_valid = 0;
  logic in_ready, set_done;
  logic [1:0] sel = 0, gate_ptr;
  logic [W-1:0] in_data = 0, out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid, out_ready = 0;
  int checks = 0, errors = 0;
  logic [W-1:0] m_d[4];
  bit m_v[4];
  int m_ptr = 0;
  bit m_done = 0;

  always #5 clk = ~clk;

  gate_demux_1to4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .auto_mode(auto_mode), .sel(sel), .ptr_clr(ptr_clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .out_valid(out_valid), .out_ready(out_ready), .gate_ptr(gate_ptr), .set_done(set_done)
  );

  function automatic logic [W-1:0] dout(int k);
    return k == 0 ? out_data0 : k == 1 ? out_data1 : k == 2 ? out_data2 : out_data3;
  endfunction

  function automatic bit exp_ready();
    int d = auto_mode ? m_ptr : int'(sel);
    return en && (!m_v[d] || out_ready[d]);
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = m_v[k];
    return r;
  endfunction

  task automatic tick();
    int d = auto_mode ? m_ptr : int'(sel);
    bit acc = in_valid && exp_ready();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin m_v[k] = 0; m_d[k] = '0; end
      m_ptr = 0;
      m_done = 0;
    end else begin
      for (int k = 0; k < 4; k++) if (m_v[k] && out_ready[k]) m_v[k] = 0;
      if (acc) begin m_d[d] = in_data; m_v[d] = 1; end
      m_done = acc && auto_mode && m_ptr == 3;
      m_ptr = ptr_clr ? 0 : (acc && auto_mode) ? (m_ptr + 1) % 4 : m_ptr;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; tick(); rst = 0;
    out_ready = 4'b0000; en = 1; auto_mode = 1; in_valid = 1;
    in_data = 64'hA0; tick();
    in_data = 64'hA1; tick();
    in_valid = 0;
    checks++; if (out_valid !== 4'b0011) begin errors++; $display("FAIL pre_reset_valid: got %b expected 0011", out_valid); end
    checks++; if (gate_ptr !== 2'd2) begin errors++; $display("FAIL pre_reset_ptr: got %0d expected 2", gate_ptr); end
    rst = 1; tick(); rst = 0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", out_valid); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (dout(k) !== '0) begin errors++; $display("FAIL reset_data%0d: got %h expected 0", k, dout(k)); end
    end
    checks++; if (gate_ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", gate_ptr); end
    checks++; if (set_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", set_done); end
  endtask

  task automatic test_auto_seq();
    out_ready = 4'b1111; en = 1; auto_mode = 1; in_valid = 1;
    for (int n = 0; n < 8; n++) begin
      in_data = 64'(16 + n);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL seq_ready%0d: got %b expected 1", n, in_ready); end
      tick();
      checks++; if (out_valid !== 4'(1 << (n % 4))) begin errors++; $display("FAIL seq_valid%0d: got %b expected %b", n, out_valid, 4'(1 << (n % 4))); end
      checks++; if (dout(n % 4) !== 64'(16 + n)) begin errors++; $display("FAIL seq_data%0d: got %h expected %h", n, dout(n % 4), 16 + n); end
      checks++; if (set_done !== (n % 4 == 3)) begin errors++; $display("FAIL seq_done%0d: got %b expected %b", n, set_done, n % 4 == 3); end
    end
    in_valid = 0; tick();
    checks++; if (gate_ptr !== 2'd0) begin errors++; $display("FAIL seq_ptr: got %0d expected 0", gate_ptr); end
    checks++; if (set_done !== 1'b0) begin errors++; $display("FAIL seq_done_end: got %b expected 0", set_done); end
  endtask

  task automatic test_backpressure();
    auto_mode = 0; sel = 2; out_ready = 4'b0000; in_valid = 1; in_data = 64'hAA;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_first: got %b expected 1", in_ready); end
    tick();
    in_data = 64'hBB;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d: got %b expected 0", c, in_ready); end
      checks++; if (out_data2 !== 64'hAA || out_valid !== 4'b0100) begin errors++; $display("FAIL bp_hold%0d: got %h/%b expected aa/0100", c, out_data2, out_valid); end
      tick();
    end
    out_ready = 4'b0100;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", in_ready); end
    tick();
    in_valid = 0; out_ready = 4'b0000;
    checks++; if (out_data2 !== 64'hBB || out_valid !== 4'b0100) begin errors++; $display("FAIL bp_reload: got %h/%b expected bb/0100", out_data2, out_valid); end
  endtask

  task automatic test_independent_drain();
    in_valid = 1; auto_mode = 0;
    out_ready = 4'b0100; sel = 0; in_data = 64'h01; tick();
    out_ready = 4'b0000; sel = 3; in_data = 64'h03; tick();
    checks++; if (out_valid !== 4'b1001) begin errors++; $display("FAIL drain_setup: got %b expected 1001", out_valid); end
    out_ready = 4'b1001; sel = 1; in_data = 64'h55; tick();
    in_valid = 0; out_ready = 4'b0000;
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL drain_valid: got %b expected 0010", out_valid); end
    checks++; if (out_data1 !== 64'h55) begin errors++; $display("FAIL drain_data1: got %h expected 55", out_data1); end
    checks++; if (out_data0 !== 64'h01 || out_data3 !== 64'h03) begin errors++; $display("FAIL drain_held: got %h/%h expected 01/03", out_data0, out_data3); end
  endtask

  task automatic test_en_ptr_clr();
    out_ready = 4'b1111; auto_mode = 1; en = 1; in_valid = 1;
    in_data = 64'h61; tick();
    in_data = 64'h62; tick();
    in_data = 64'h63; tick();
    checks++; if (gate_ptr !== 2'd3) begin errors++; $display("FAIL en_ptr_setup: got %0d expected 3", gate_ptr); end
    in_data = 64'h64; tick();
    in_data = 64'h65; tick();
    checks++; if (gate_ptr !== 2'd1) begin errors++; $display("FAIL en_ptr_wrap: got %0d expected 1", gate_ptr); end
    in_data = 64'h66; tick();
    en = 0; out_ready = 4'b0000; in_data = 64'h99;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_ready: got %b expected 0", in_ready); end
    tick();
    checks++; if (gate_ptr !== 2'd2 || out_valid !== 4'b0010 || set_done !== 1'b0) begin errors++; $display("FAIL en_hold: got %0d/%b/%b expected 2/0010/0", gate_ptr, out_valid, set_done); end
    en = 1; ptr_clr = 1; in_data = 64'h77; tick();
    ptr_clr = 0; in_valid = 0;
    checks++; if (out_data2 !== 64'h77 || out_valid !== 4'b0110) begin errors++; $display("FAIL clr_data: got %h/%b expected 77/0110", out_data2, out_valid); end
    checks++; if (gate_ptr !== 2'd0) begin errors++; $display("FAIL clr_ptr: got %0d expected 0", gate_ptr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 59) == 0;
      en = $urandom_range(0, 5) != 0;
      auto_mode = $urandom_range(0, 2) != 0;
      sel = 2'($urandom_range(0, 3));
      ptr_clr = $urandom_range(0, 9) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      in_data = {$urandom, $urandom};
      out_ready = 4'($urandom_range(0, 15));
      #1;
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", i, in_ready, exp_ready()); end
      tick();
      checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", i, out_valid, exp_valid()); end
      checks++; if (gate_ptr !== 2'(m_ptr)) begin errors++; $display("FAIL rnd_ptr@%0d: got %0d expected %0d", i, gate_ptr, m_ptr); end
      checks++; if (set_done !== m_done) begin errors++; $display("FAIL rnd_done@%0d: got %b expected %b", i, set_done, m_done); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (dout(k) !== m_d[k]) begin errors++; $display("FAIL rnd_data%0d@%0d: got %h expected %h", k, i, dout(k), m_d[k]); end
      end
    end
    rst = 0; ptr_clr = 0; in_valid = 0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin m_v[k] = 0; m_d[k] = '0; end
    @(posedge clk); #1;
    test_reset();
    test_auto_seq();
    test_backpressure();
    test_independent_drain();
    test_en_ptr_clr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
